// File: rtl/hilo_muldiv_unit.sv
// hilo_muldiv_unit: iterative multiply/divide engine that owns the HI/LO pair.
// Multiplies use shift-add, divides use restoring subtraction, both on operand
// magnitudes; signs are re-applied in a single FIX cycle before HI/LO are written.
// Optional build macro MULDIV_DIV0_FLAG_EN: adds a Div0 output and lets a divide
// by zero skip the iteration phase (IDLE -> FIX directly).
module hilo_muldiv_unit #(
  parameter int WIDTH          = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Start,
  input  logic [2:0]       Op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             HiLoRead,
  input  logic             Flush,
  output logic             Busy,
  output logic             Stall,
  output logic             Done,
  output logic [WIDTH-1:0] Hi_out,
  output logic [WIDTH-1:0] Lo_out
`ifdef MULDIV_DIV0_FLAG_EN
  ,
  output logic             Div0
`endif
);

  localparam int N  = WIDTH / BITS_PER_CYCLE;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MADD  = 3'b100;
  localparam logic [2:0] OP_MSUB  = 3'b101;
  localparam logic [2:0] OP_MTHI  = 3'b110;
  localparam logic [2:0] OP_MTLO  = 3'b111;

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q;
  logic [2:0]           op_q;
  logic                 a_neg_q;
  logic                 res_neg_q;
  logic                 div0_q;
  logic [WIDTH-1:0]     m_q;
  logic [2*WIDTH-1:0]   p_q;
  logic [2*WIDTH-1:0]   p_iter;
  logic [WIDTH-1:0]     hi_q, lo_q;
  logic                 done_q;
  logic [2*WIDTH-1:0]   fix_result;

  // One shift-add step: conditionally add the multiplicand into the upper half,
  // then shift the whole {carry, upper, lower} right by one.
  function automatic logic [2*WIDTH-1:0] mul_step(input logic [2*WIDTH-1:0] p,
                                                  input logic [WIDTH-1:0]   m);
    logic [WIDTH:0] sum;
    sum = {1'b0, p[2*WIDTH-1:WIDTH]} + (p[0] ? {1'b0, m} : {(WIDTH+1){1'b0}});
    return {sum, p[WIDTH-1:1]};
  endfunction

  // One restoring-divide step: shift the next dividend bit into the partial
  // remainder, keep the difference if it did not go negative, record the bit.
  function automatic logic [2*WIDTH-1:0] div_step(input logic [2*WIDTH-1:0] p,
                                                  input logic [WIDTH-1:0]   d);
    logic [WIDTH:0] rs;
    logic [WIDTH:0] diff;
    rs   = {p[2*WIDTH-1:WIDTH], p[WIDTH-1]};
    diff = rs - {1'b0, d};
    if (!diff[WIDTH]) return {diff[WIDTH-1:0], p[WIDTH-2:0], 1'b1};
    else              return {rs[WIDTH-1:0],   p[WIDTH-2:0], 1'b0};
  endfunction

  // Operand decode in the accepting cycle.
  logic             in_signed, in_div, in_mt, in_b_zero;
  logic             a_neg_in, b_neg_in, div0_skip;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic             accept, accept_run;

  assign in_mt      = (Op == OP_MTHI) || (Op == OP_MTLO);
  assign in_div     = (Op == OP_DIV) || (Op == OP_DIVU);
  assign in_signed  = (Op == OP_MULT) || (Op == OP_DIV) || (Op == OP_MADD) || (Op == OP_MSUB);
  assign in_b_zero  = (B == {WIDTH{1'b0}});
  assign a_neg_in   = in_signed & A[WIDTH-1];
  assign b_neg_in   = in_signed & B[WIDTH-1];
  assign a_mag      = a_neg_in ? -A : A;
  assign b_mag      = b_neg_in ? -B : B;
  assign accept     = (state_q == IDLE) & Start & ~Flush;
  assign accept_run = accept & ~in_mt;
`ifdef MULDIV_DIV0_FLAG_EN
  assign div0_skip  = in_div & in_b_zero;
`else
  assign div0_skip  = 1'b0;
`endif

  // FSM state register.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // FSM next state: Flush always returns to IDLE; Start is only taken in IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept_run) state_d = div0_skip ? FIX : RUN;
      RUN:  if (Flush) state_d = IDLE;
            else if (cnt_q == LAST) state_d = FIX;
      FIX:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // BITS_PER_CYCLE iteration steps chained combinationally.
  always_comb begin
    p_iter = p_q;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      if ((op_q == OP_DIV) || (op_q == OP_DIVU)) p_iter = div_step(p_iter, m_q);
      else                                       p_iter = mul_step(p_iter, m_q);
    end
  end

  // Operand latch on accept, then one iteration per RUN cycle.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      cnt_q     <= '0;
      op_q      <= '0;
      a_neg_q   <= 1'b0;
      res_neg_q <= 1'b0;
      div0_q    <= 1'b0;
      m_q       <= '0;
      p_q       <= '0;
    end else if (accept_run) begin
      cnt_q     <= '0;
      op_q      <= Op;
      a_neg_q   <= a_neg_in;
      res_neg_q <= a_neg_in ^ b_neg_in;
      div0_q    <= in_div & in_b_zero;
      if (in_div) begin
        m_q <= b_mag;
        // A skipped divide-by-zero parks |A| where the remainder would end up.
        p_q <= div0_skip ? {a_mag, {WIDTH{1'b0}}} : {{WIDTH{1'b0}}, a_mag};
      end else begin
        m_q <= a_mag;
        p_q <= {{WIDTH{1'b0}}, b_mag};
      end
    end else if (state_q == RUN) begin
      cnt_q <= cnt_q + CW'(1);
      p_q   <= p_iter;
    end
  end

  // Sign correction and accumulate, evaluated during FIX against current HI/LO.
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quot, rem;

  always_comb begin
    prod = res_neg_q ? -p_q : p_q;
    quot = res_neg_q ? -p_q[WIDTH-1:0] : p_q[WIDTH-1:0];
    rem  = a_neg_q ? -p_q[2*WIDTH-1:WIDTH] : p_q[2*WIDTH-1:WIDTH];
    case (op_q)
      OP_MULT, OP_MULTU: fix_result = prod;
      OP_MADD:           fix_result = {hi_q, lo_q} + prod;
      OP_MSUB:           fix_result = {hi_q, lo_q} - prod;
      OP_DIV, OP_DIVU:   fix_result = {rem, div0_q ? {WIDTH{1'b1}} : quot};
      default:           fix_result = {hi_q, lo_q};
    endcase
  end

  // Architectural HI/LO: moves write on accept, multi-cycle ops leaving FIX.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (accept && (Op == OP_MTHI)) begin
      hi_q <= A;
    end else if (accept && (Op == OP_MTLO)) begin
      lo_q <= A;
    end else if ((state_q == FIX) && !Flush) begin
      {hi_q, lo_q} <= fix_result;
    end
  end

  // Done pulses for the cycle after a completed FIX write.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) done_q <= 1'b0;
    else      done_q <= (state_q == FIX) & ~Flush;
  end

`ifdef MULDIV_DIV0_FLAG_EN
  logic div0_flag_q;

  // Div0 accompanies the Done pulse of a divide by zero.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) div0_flag_q <= 1'b0;
    else      div0_flag_q <= (state_q == FIX) & ~Flush & div0_q;
  end

  assign Div0 = div0_flag_q;
`endif

  assign Busy   = (state_q != IDLE);
  assign Stall  = Busy & (HiLoRead | Start);
  assign Done   = done_q;
  assign Hi_out = hi_q;
  assign Lo_out = lo_q;

endmodule
